// File: rtl/pwm_breath_pkg.sv
// Shared constants and helpers for the breathing PWM generator.
package pwm_breath_pkg;

  localparam logic [1:0] MODE_TRI  = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;

  // Ramp direction of a channel while in triangle mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Reset level of channel idx: channels are spread evenly over the level range.
  function automatic int unsigned phase_offset(input int unsigned idx,
                                               input int unsigned duty_w,
                                               input int unsigned n_ch);
    return idx * ((32'd1 << duty_w) / n_ch);
  endfunction

endpackage

// File: rtl/pwm_breath_chan.sv
// One channel: level/direction register, pattern step on tick, PWM comparator.
module pwm_breath_chan
  import pwm_breath_pkg::*;
#(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CH_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] carrier,
  output logic [DUTY_W-1:0] level,
  output logic              pwm
);

  localparam logic [DUTY_W-1:0] LVL_MAX = '1;
  localparam logic [DUTY_W-1:0] LVL_ONE = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] LVL_RST = DUTY_W'(phase_offset(CH_IDX, DUTY_W, N_CH));

  logic [DUTY_W-1:0] level_nxt;
  dir_t              dir_q;
  dir_t              dir_nxt;

  // Level and direction registers; phase offset on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= LVL_RST;
      dir_q <= DIR_UP;
    end else begin
      level <= level_nxt;
      dir_q <= dir_nxt;
    end
  end

  // Next level: triangle bounces at the ends, sawtooth wraps, hold (and mode 3) freezes.
  always_comb begin
    level_nxt = level;
    dir_nxt   = dir_q;
    if (step) begin
      case (mode)
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            if (level == LVL_MAX) begin
              level_nxt = LVL_MAX - LVL_ONE;
              dir_nxt   = DIR_DOWN;
            end else begin
              level_nxt = level + LVL_ONE;
            end
          end else begin
            if (level == '0) begin
              level_nxt = LVL_ONE;
              dir_nxt   = DIR_UP;
            end else begin
              level_nxt = level - LVL_ONE;
            end
          end
        end
        MODE_SAW: level_nxt = level + LVL_ONE;
        default:  level_nxt = level;
      endcase
    end
  end

  // Registered comparator; forced low while the block is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= run & (carrier < level);
  end

endmodule

// File: rtl/pwm_breath_gen.sv
// N-channel breathing PWM: shared prescaler and carrier, one level engine per channel.
module pwm_breath_gen
  import pwm_breath_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DUTY_W    = 8,
  parameter int unsigned PRESC_W   = 20,
  parameter int unsigned PRESC_RST = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   presc_load,
  input  logic [PRESC_W-1:0]     presc_val,
  output logic [N_CH*DUTY_W-1:0] level_out,
  output logic [N_CH-1:0]        pwm_out,
  output logic                   tick_out
);

  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);
  localparam logic [DUTY_W-1:0]  CAR_ONE  = DUTY_W'(1);

  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] pcnt;
  logic [DUTY_W-1:0]  carrier;
  logic               tick;

  // A load suppresses the tick of its own cycle and restarts the count.
  assign tick = enable & ~presc_load & (pcnt == presc_reg);

  // Prescaler reload register and divide counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= PRESC_W'(PRESC_RST);
      pcnt      <= '0;
    end else if (presc_load) begin
      presc_reg <= presc_val;
      pcnt      <= '0;
    end else if (enable) begin
      pcnt <= tick ? '0 : pcnt + PCNT_ONE;
    end
  end

  // Free-running carrier and the registered tick pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier  <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= tick;
      if (enable) carrier <= carrier + CAR_ONE;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pwm_breath_chan #(
      .DUTY_W (DUTY_W),
      .N_CH   (N_CH),
      .CH_IDX (i)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .run     (enable),
      .step    (tick),
      .mode    (mode),
      .carrier (carrier),
      .level   (level_out[i*DUTY_W +: DUTY_W]),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_breath_gen.sv
// Self-checking bench for pwm_breath_gen with a behavioural level model.
module tb_pwm_breath_gen;

  localparam int N_CH      = 4;
  localparam int DUTY_W    = 8;
  localparam int PRESC_W   = 20;
  localparam int PRESC_RST = 1000000;
  localparam int MAXV      = (1 << DUTY_W) - 1;
  localparam int SPAN      = 1 << DUTY_W;

  // ---------------- clock / reset ----------------
  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic [1:0]             mode;
  logic                   presc_load;
  logic [PRESC_W-1:0]     presc_val;
  logic [N_CH*DUTY_W-1:0] level_out;
  logic [N_CH-1:0]        pwm_out;
  logic                   tick_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_breath_gen #(
    .N_CH      (N_CH),
    .DUTY_W    (DUTY_W),
    .PRESC_W   (PRESC_W),
    .PRESC_RST (PRESC_RST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .presc_load (presc_load),
    .presc_val  (presc_val),
    .level_out  (level_out),
    .pwm_out    (pwm_out),
    .tick_out   (tick_out)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Levels are tracked as (level, rising) pairs; a triangle step is a move of one
  // position around a 2*MAX-long loop, folded back into a level.
  int          m_lvl[N_CH];
  bit          m_up[N_CH];
  int          m_presc;
  int          m_since;
  int          m_car;
  bit          m_tick;
  logic [N_CH-1:0] m_pwm;

  function automatic int tri_at(input int p);
    int q;
    q = p % (2 * MAXV);
    return (q <= MAXV) ? q : 2 * MAXV - q;
  endfunction

  function automatic void model_step_level(input int ch, input logic [1:0] md);
    int pos;
    int nl;
    if (md == 2'd0) begin
      pos = m_up[ch] ? m_lvl[ch] : (2 * MAXV - m_lvl[ch]) % (2 * MAXV);
      nl  = tri_at(pos + 1);
      m_up[ch]  = (nl > m_lvl[ch]);
      m_lvl[ch] = nl;
    end else if (md == 2'd1) begin
      m_lvl[ch] = (m_lvl[ch] + 1) % SPAN;
    end
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_lvl[ch] = ch * (SPAN / N_CH);
      m_up[ch]  = 1'b1;
    end
    m_presc = PRESC_RST;
    m_since = 0;
    m_car   = 0;
    m_tick  = 1'b0;
    m_pwm   = '0;
  endfunction

  function automatic void model_clock();
    bit fire;
    fire = enable && !presc_load && (m_since == m_presc);
    for (int ch = 0; ch < N_CH; ch++) m_pwm[ch] = enable && (m_car < m_lvl[ch]);
    m_tick = fire;
    if (fire) for (int ch = 0; ch < N_CH; ch++) model_step_level(ch, mode);
    if (presc_load) begin
      m_presc = int'(presc_val);
      m_since = 0;
    end else if (enable) begin
      m_since = fire ? 0 : m_since + 1;
    end
    if (enable) m_car = (m_car + 1) % SPAN;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_clock();
  end

  // Scoreboard: every output compared against the model each cycle, mid-period.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      for (int ch = 0; ch < N_CH; ch++)
        check($sformatf("lvl%0d", ch), level_out[ch*DUTY_W +: DUTY_W], m_lvl[ch]);
      check("pwm", pwm_out, m_pwm);
      check("tick", tick_out, m_tick);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_cycles(2);
    rst = 1'b0;
  endtask

  // Load a reload value and count edges until tick_out shows up.
  task automatic load_and_time(input int val, output int n);
    bit found;
    presc_val  = PRESC_W'(val);
    presc_load = 1'b1;
    step_cycles(1);
    presc_load = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (tick_out) found = 1;
    end
    if (!found) check("tick_timeout", 0, 1);
  endtask

  task automatic time_next_tick(output int n);
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (tick_out) found = 1;
    end
    if (!found) check("gap_timeout", 0, 1);
  endtask

  task automatic measure_duty(output int cnt[N_CH]);
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = 0;
    repeat (SPAN) begin
      @(negedge clk);
      for (int ch = 0; ch < N_CH; ch++) cnt[ch] += int'(pwm_out[ch]);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt[N_CH];
    int nz;
    int tk;
    int vals[3];

    vals[0] = 3; vals[1] = 1; vals[2] = 6;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; presc_load = 1'b0; presc_val = '0;
    #23;
    // reset state
    for (int ch = 0; ch < N_CH; ch++)
      check($sformatf("rst_lvl%0d", ch), level_out[ch*DUTY_W +: DUTY_W], ch * (SPAN / N_CH));
    check("rst_pwm", pwm_out, 0);
    check("rst_tick", tick_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1;

    // triangle with tick every cycle
    enable = 1'b1; mode = 2'd0; presc_val = '0; presc_load = 1'b1;
    step_cycles(1);
    presc_load = 1'b0;
    step_cycles(300);
    check("tri_ch0_300", level_out[0 +: DUTY_W], tri_at(300));
    check("tri_ch2_300", level_out[2*DUTY_W +: DUTY_W], tri_at(128 + 300));
    step_cycles(220);
    check("tri_ch0_520", level_out[0 +: DUTY_W], tri_at(520));
    check("tri_ch2_520", level_out[2*DUTY_W +: DUTY_W], tri_at(128 + 520));

    // sawtooth, then back to triangle with stored direction
    mode = 2'd1;
    step_cycles(300);
    mode = 2'd0;
    step_cycles(200);

    // prescaler timing for several reload values, including reload mid-count
    mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      load_and_time(vals[k], n);
      check($sformatf("load_to_tick_%0d", vals[k]), n, vals[k] + 1);
      time_next_tick(n);
      check($sformatf("tick_gap_%0d", vals[k]), n, vals[k] + 1);
      @(posedge clk); #1;
      step_cycles(1);
      load_and_time(vals[k], n);
      check($sformatf("midload_%0d", vals[k]), n, vals[k] + 1);
      @(posedge clk); #1;
    end

    // freeze for 100 cycles
    mode = 2'd0;
    step_cycles(37);
    enable = 1'b0;
    nz = 0; tk = 0;
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
      nz += (pwm_out != 0) ? 1 : 0;
      tk += int'(tick_out);
    end
    check("frz_pwm_high", nz, 0);
    check("frz_ticks", tk, 0);
    @(posedge clk); #1;
    enable = 1'b1;
    step_cycles(50);

    // randomized mix
    repeat (3000) begin
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      presc_load = ($urandom_range(0, 49) == 0);
      presc_val  = PRESC_W'($urandom_range(0, 3));
      step_cycles(1);
    end
    presc_load = 1'b0;
    enable = 1'b1;

    // duty at reset levels 0, 64, 128, 192
    mode = 2'd2;
    do_reset();
    step_cycles(2);
    measure_duty(cnt);
    for (int ch = 0; ch < N_CH; ch++)
      check($sformatf("duty_rst%0d", ch), cnt[ch], ch * (SPAN / N_CH));

    // ramp 63 steps so ch3 sits at MAX, then hold and measure
    mode = 2'd0; presc_val = '0; presc_load = 1'b1;
    step_cycles(1);
    presc_load = 1'b0;
    step_cycles(63);
    mode = 2'd2;
    check("ch3_at_max", level_out[3*DUTY_W +: DUTY_W], MAXV);
    step_cycles(2);
    measure_duty(cnt);
    for (int ch = 0; ch < N_CH; ch++)
      check($sformatf("duty_ramp%0d", ch), cnt[ch], 63 + ch * (SPAN / N_CH));

    // asynchronous reset between clock edges
    mode = 2'd0;
    step_cycles(50);
    #2;
    rst = 1'b1;
    #1;
    for (int ch = 0; ch < N_CH; ch++)
      check($sformatf("arst_lvl%0d", ch), level_out[ch*DUTY_W +: DUTY_W], ch * (SPAN / N_CH));
    check("arst_pwm", pwm_out, 0);
    check("arst_tick", tick_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step_cycles(20);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
